// File: rtl/pad_bidir_xcvr.sv
// Half-duplex UART-style transceiver driving one PADBID cell (I/OEN out, C back).
// Optional even-parity bit enabled by defining PAD_XCVR_PARITY_EN.
module pad_bidir_xcvr #(
  parameter int WIDTH       = 8,
  parameter int BIT_CYC     = 4,
  parameter int TURN_CYC    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_en,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_err,
  output logic             pad_i,
  output logic             pad_oen,
  input  logic             pad_c,
  output logic             busy
);

`ifdef PAD_XCVR_PARITY_EN
  localparam int FRAME = WIDTH + 3;
`else
  localparam int FRAME = WIDTH + 2;
`endif
  localparam int CMAX = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(FRAME + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_DRV  = 3'd1,
    TX_BITS = 3'd2,
    TX_REL  = 3'd3,
    RX_BITS = 3'd4
  } state_t;

`ifdef PAD_XCVR_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [FRAME-1:0]   tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0]   rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_err_q, rx_err_d;
  logic               pad_i_q, pad_i_d;
  logic               pad_oen_q, pad_oen_d;
  logic               busy_q, busy_d;
  logic               tx_ready_q, tx_ready_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic               prev_q, prev_d;
  logic               synced_s, fall_s, par_ok_s;
`ifdef PAD_XCVR_PARITY_EN
  logic               rx_par_q, rx_par_d;
`endif

  assign synced_s = sync_q[SYNC_STAGES-1];
  assign fall_s   = prev_q & ~synced_s;
  // RX start takes priority over a transmit offered in the same cycle.
  assign tx_ready = tx_ready_q & ~(rx_en & fall_s);

  assign pad_i    = pad_i_q;
  assign pad_oen  = pad_oen_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign rx_data  = rx_data_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_c};
    prev_d = synced_s;
`ifdef PAD_XCVR_PARITY_EN
    par_ok_s = (rx_par_q == even_par(rx_sh_q));
`else
    par_ok_s = 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
`ifdef PAD_XCVR_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_en && fall_s) begin
          // The edge cycle is phase 0 of the start bit.
          state_d = RX_BITS;
          cnt_d   = CW'(1);
          bit_d   = '0;
        end else if (tx_valid && tx_ready) begin
          state_d = TX_DRV;
          cnt_d   = '0;
`ifdef PAD_XCVR_PARITY_EN
          tx_sh_d = {1'b1, even_par(tx_data), tx_data, 1'b0};
`else
          tx_sh_d = {1'b1, tx_data, 1'b0};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      TX_DRV: begin
        if (cnt_q == CW'(TURN_CYC - 1)) begin
          state_d = TX_BITS;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_BITS: begin
        if (cnt_q == CW'(BIT_CYC - 1)) begin
          cnt_d = '0;
          if (bit_q == BW'(FRAME - 1)) begin
            state_d = TX_REL;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_sh_d = {1'b1, tx_sh_q[FRAME-1:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_REL: begin
        if (cnt_q == CW'(TURN_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_BITS: begin
        if (cnt_q == CW'(BIT_CYC / 2)) begin
          cnt_d = cnt_q + CW'(1);
          if (bit_q == BW'(0)) begin
            if (synced_s) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RX_BITS;
            end
          end else if (bit_q == BW'(FRAME - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (synced_s && par_ok_s) begin
              rx_data_d  = rx_sh_q;
              rx_valid_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
`ifdef PAD_XCVR_PARITY_EN
          end else if (bit_q == BW'(WIDTH + 1)) begin
            rx_par_d = synced_s;
`endif
          end else begin
            rx_sh_d = {synced_s, rx_sh_q[WIDTH-1:1]};
          end
        end else if (cnt_q == CW'(BIT_CYC - 1)) begin
          cnt_d = '0;
          bit_d = bit_q + BW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Pad controls are registered from next state so they align with state_q.
    pad_oen_d  = ~((state_d == TX_DRV) || (state_d == TX_BITS));
    pad_i_d    = (state_d == TX_BITS) ? tx_sh_d[0] : 1'b1;
    busy_d     = (state_d != IDLE);
    tx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '1;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      pad_i_q    <= 1'b1;
      pad_oen_q  <= 1'b1;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      sync_q     <= '1;
      prev_q     <= 1'b1;
`ifdef PAD_XCVR_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      pad_i_q    <= pad_i_d;
      pad_oen_q  <= pad_oen_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
`ifdef PAD_XCVR_PARITY_EN
      rx_par_q   <= rx_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_pad_bidir_xcvr.sv
// Self-checking bench for pad_bidir_xcvr: directed steps plus randomized frames
// checked against a frame-level model; the pad is modelled as a shared wire.
module tb_pad_bidir_xcvr;
  localparam int W    = 8;
  localparam int BIT  = 4;
  localparam int TURN = 2;
  localparam int SYNC = 2;
`ifdef PAD_XCVR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = W + 2 + PAR;

  logic clk = 1'b0;
  logic rst, tx_valid, rx_en, ext_drv;
  logic [W-1:0] tx_data;
  logic tx_ready, rx_valid, rx_err, pad_i, pad_oen, busy, pad_c;
  logic [W-1:0] rx_data;

  // The pad: our driver wins while OEN is low, otherwise the far end drives.
  assign pad_c = pad_oen ? ext_drv : pad_i;

  always #5 clk = ~clk;

  pad_bidir_xcvr #(.WIDTH(W), .BIT_CYC(BIT), .TURN_CYC(TURN), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .pad_i(pad_i), .pad_oen(pad_oen), .pad_c(pad_c), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0;
  int n_acc = 0, n_err = 0, n_viol = 0, n_busy = 0, n_notready = 0;
  int rx_acc_mark = -1, rx_txq_mark = -1;
  logic txq[$];
  logic [W-1:0] rxq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line level of frame bit b for byte d (start, data LSB first, [parity], stop).
  function automatic logic frame_bit(input logic [W-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    if (PAR == 1 && b == W + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic tick();
    logic acc;
    acc = tx_valid && tx_ready;
    @(posedge clk); #1;
    if (acc) begin tx_valid = 1'b0; n_acc++; n_notready = 0; end
    if (!pad_oen) txq.push_back(pad_i);
    if (rx_valid) begin rxq.push_back(rx_data); rx_acc_mark = n_acc; rx_txq_mark = txq.size(); end
    if (rx_err) n_err++;
    if (rx_valid && rx_err) n_viol++;
    if (busy) n_busy++;
    if (!tx_ready) n_notready++;
  endtask

  task automatic check_tx(input string tag, input logic [W-1:0] d);
    logic exp_q[$];
    int mism;
    for (int i = 0; i < TURN; i++) exp_q.push_back(1'b1);
    for (int b = 0; b < FRAME; b++)
      for (int c = 0; c < BIT; c++) exp_q.push_back(frame_bit(d, b));
    check({tag, "_oen_low_len"}, txq.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
      if (txq[i] !== exp_q[i]) mism++;
    check({tag, "_bits"}, mism, 0);
    txq.delete();
  endtask

  task automatic do_tx(input logic [W-1:0] d, input string tag);
    int guard, n0;
    txq.delete();
    tx_data = d; tx_valid = 1'b1; n0 = n_acc; guard = 0;
    while (n_acc == n0 && guard < 100) begin tick(); guard++; end
    check({tag, "_accepted"}, n_acc - n0, 1);
    guard = 0;
    while (!tx_ready && guard < 300) begin tick(); guard++; end
    check({tag, "_ready_low"}, n_notready, 2 * TURN + FRAME * BIT);
    check_tx(tag, d);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop_bit, input logic drop_en);
    for (int b = 0; b < FRAME; b++) begin
      ext_drv = (b == FRAME - 1) ? stop_bit : frame_bit(d, b);
      for (int c = 0; c < BIT; c++) begin
        if (drop_en && b == 2 && c == 0) rx_en = 1'b0;
        tick();
      end
    end
    ext_drv = 1'b1;
    repeat (10) tick();
    rx_en = 1'b1;
  endtask

  initial begin
    logic [W-1:0] d, exp_data;
    logic stop;
    int guard, n_acc0;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_en = 1'b1; ext_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pad_oen", 32'(pad_oen), 1);
    check("rst_pad_i", 32'(pad_i), 1);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_err", 32'(rx_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0; #1;
    check("ready_before_edge", 32'(tx_ready), 0);
    tick();
    check("ready_after_rst", 32'(tx_ready), 1);

    // TX basic, with rx_en high to show our own echo is not received.
    rxq.delete(); n_err = 0;
    do_tx(8'hA5, "tx_a5");
    check("tx_a5_no_self_rx", rxq.size() + n_err, 0);

    // RX basic.
    rxq.delete(); n_err = 0; txq.delete();
    send_frame(8'h3C, 1'b1, 1'b0);
    check("rx_3c_count", rxq.size(), 1);
    check("rx_3c_data", 32'(rxq[0]), 32'h3C);
    check("rx_3c_err", n_err, 0);
    check("rx_3c_oen_high", txq.size(), 0);
    check("rx_3c_held", 32'(rx_data), 32'h3C);
    exp_data = 8'h3C;

    // Randomized frames: random byte, occasional bad stop, rx_en dropped mid-frame.
    for (int i = 0; i < 6; i++) begin
      d = W'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rxq.delete(); n_err = 0;
      send_frame(d, stop, 1'($urandom_range(0, 1)));
      if (stop) exp_data = d;
      check($sformatf("rnd%0d_count", i), rxq.size(), stop ? 1 : 0);
      check($sformatf("rnd%0d_err", i), n_err, stop ? 0 : 1);
      check($sformatf("rnd%0d_data", i), 32'(rx_data), 32'(exp_data));
    end

    // Glitch: one-clock low is a false start.
    rxq.delete(); n_err = 0; n_busy = 0;
    ext_drv = 1'b0; tick(); ext_drv = 1'b1;
    repeat (10) tick();
    check("glitch_busy_cycles", n_busy, BIT / 2);
    check("glitch_no_valid", rxq.size(), 0);
    check("glitch_no_err", n_err, 0);
    check("glitch_idle", 32'(busy), 0);

    // Bad stop keeps previous data.
    rxq.delete(); n_err = 0;
    send_frame(8'h55, 1'b0, 1'b0);
    check("badstop_err", n_err, 1);
    check("badstop_no_valid", rxq.size(), 0);
    check("badstop_data_kept", 32'(rx_data), 32'(exp_data));

    // Collision: tx_valid raised on the synchronised falling edge of an incoming frame.
    rxq.delete(); txq.delete(); n_acc0 = n_acc; rx_acc_mark = -1; rx_txq_mark = -1;
    ext_drv = 1'b0; tick(); tick();
    tx_data = 8'h81; tx_valid = 1'b1;
    check("coll_ready_low", 32'(tx_ready), 0);
    for (int c = 0; c < BIT - 2; c++) tick();
    for (int b = 1; b < FRAME; b++) begin
      ext_drv = frame_bit(8'h42, b);
      for (int c = 0; c < BIT; c++) tick();
    end
    ext_drv = 1'b1;
    guard = 0;
    while ((n_acc == n_acc0 || !tx_ready) && guard < 400) begin tick(); guard++; end
    check("coll_rx_count", rxq.size(), 1);
    check("coll_rx_data", 32'(rxq[0]), 32'h42);
    check("coll_rx_before_tx", rx_acc_mark, n_acc0);
    check("coll_oen_high_during_rx", rx_txq_mark, 0);
    check("coll_tx_accepted", n_acc - n_acc0, 1);
    check_tx("coll_tx81", 8'h81);

    // Random transmits.
    for (int i = 0; i < 3; i++) do_tx(W'($urandom), $sformatf("rtx%0d", i));

    // Reset during data bit 3 (bit forced to 0 so the release to 1 is visible).
    d = W'($urandom) & 8'hF7;
    tx_data = d; tx_valid = 1'b1;
    tick();
    repeat (19) tick();
    check("rstmid_pre_oen", 32'(pad_oen), 0);
    check("rstmid_pre_bit3", 32'(pad_i), 0);
    #2 rst = 1'b1; #1;
    check("rstmid_oen_async", 32'(pad_oen), 1);
    check("rstmid_pad_i_async", 32'(pad_i), 1);
    check("rstmid_busy_async", 32'(busy), 0);
    check("rstmid_ready_async", 32'(tx_ready), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; txq.delete();
    tick();
    check("rstmid_ready_after", 32'(tx_ready), 1);
    repeat (30) tick();
    check("rstmid_no_residual", txq.size(), 0);
    check("rstmid_idle", 32'(busy), 0);

    check("no_valid_err_overlap", n_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
